// File: rtl/pipe_controlunit.sv
// Pipelined RV32I control unit: decodes in D, carries control through ID/EX, EX/MEM, MEM/WB and resolves branches in E.
// Optional macro CTRL_ILLEGAL_TRAP_EN: flag unsupported encodings on illegalD (they always enter E as a bubble).
module pipe_controlunit #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instrD,
  input  logic                 validD,
  input  logic                 flushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [IMMSRC_W-1:0]  ImmSrcD,
  output logic                 illegalD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 ALUSrcAE,
  output logic [1:0]           PCSrcE,
  output logic                 RegWriteE,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcE,
  output logic [1:0]           ResultSrcW,
  output logic                 MemWriteM,
  output logic [2:0]           funct3M
);

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       alu_src_a;
    logic [2:0] funct3;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_alt;
  logic [3:0] alu_op;
  logic       r_funct7_ok;
  logic       legal;
  logic [2:0] imm_src;
  ctrl_t      ctrl_d;
  logic       kill_d;
  logic       branch_taken;
  logic       unused_instr_bits;

  ctrl_t      ctrl_e_reg;
  logic       reg_write_m_reg;
  logic [1:0] result_src_m_reg;
  logic       mem_write_m_reg;
  logic [2:0] funct3_m_reg;
  logic       reg_write_w_reg;
  logic [1:0] result_src_w_reg;

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign funct7 = instrD[31:25];
  // Register specifiers and immediate bits are handled by the datapath.
  assign unused_instr_bits = ^{instrD[24:15], instrD[11:7]};

  // funct7[5] only distinguishes R-type sub from add, and sra from srl.
  assign alu_alt = funct7[5] & ((funct3 == 3'b101) | ((opcode == OP_R) & (funct3 == 3'b000)));
  assign r_funct7_ok = (funct7 == 7'h00) |
                       ((funct7 == 7'h20) & ((funct3 == 3'b000) | (funct3 == 3'b101)));

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = alu_alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = alu_alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl_d  = '0;
    imm_src = 3'b000;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        legal              = r_funct7_ok;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = alu_op;
      end
      OP_I: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = alu_op;
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b01;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_STORE: begin
        imm_src          = 3'b001;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        imm_src            = 3'b010;
        legal              = (funct3[2:1] != 2'b01);
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        imm_src           = 3'b011;
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
      end
      OP_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.jalr       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_LUI: begin
        imm_src            = 3'b100;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm_src          = 3'b100;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings never carry side effects, trap or not.
    if (!legal) begin
      ctrl_d = '0;
    end else begin
      ctrl_d.funct3 = funct3;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegalD = ~legal;
`else
  assign illegalD = 1'b0;
`endif

  assign kill_d = flushE | ~validD | illegalD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_e_reg       <= '0;
      reg_write_m_reg  <= 1'b0;
      result_src_m_reg <= 2'b00;
      mem_write_m_reg  <= 1'b0;
      funct3_m_reg     <= 3'b000;
      reg_write_w_reg  <= 1'b0;
      result_src_w_reg <= 2'b00;
    end else begin
      ctrl_e_reg       <= kill_d ? '0 : ctrl_d;
      reg_write_m_reg  <= ctrl_e_reg.reg_write;
      result_src_m_reg <= ctrl_e_reg.result_src;
      mem_write_m_reg  <= ctrl_e_reg.mem_write;
      funct3_m_reg     <= ctrl_e_reg.funct3;
      reg_write_w_reg  <= reg_write_m_reg;
      result_src_w_reg <= result_src_m_reg;
    end
  end

  always_comb begin
    case (ctrl_e_reg.funct3)
      3'b000:  branch_taken = ZeroE;
      3'b001:  branch_taken = ~ZeroE;
      3'b100:  branch_taken = LtE;
      3'b101:  branch_taken = ~LtE;
      3'b110:  branch_taken = LtuE;
      3'b111:  branch_taken = ~LtuE;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    PCSrcE = 2'b00;
    if (ctrl_e_reg.jalr) begin
      PCSrcE = 2'b10;
    end else if (ctrl_e_reg.jump | (ctrl_e_reg.branch & branch_taken)) begin
      PCSrcE = 2'b01;
    end
  end

  assign ImmSrcD     = IMMSRC_W'(imm_src);
  assign ALUControlE = ALUCTRL_W'(ctrl_e_reg.alu_control);
  assign ALUSrcE     = ctrl_e_reg.alu_src;
  assign ALUSrcAE    = ctrl_e_reg.alu_src_a;
  assign RegWriteE   = ctrl_e_reg.reg_write;
  assign ResultSrcE  = ctrl_e_reg.result_src;
  assign RegWriteM   = reg_write_m_reg;
  assign MemWriteM   = mem_write_m_reg;
  assign funct3M     = funct3_m_reg;
  assign RegWriteW   = reg_write_w_reg;
  assign ResultSrcW  = result_src_w_reg;

endmodule

// File: doc/pipe_controlunit.md
# pipe_controlunit

Pipelined RV32I control unit for the five-stage core. Decodes the instruction in Decode and carries the control word through ID/EX, EX/MEM and MEM/WB registers. Resolves all six conditional branches plus jal/jalr in Execute from ALU flags. Takes a flush from the hazard unit and exports per-stage RegWrite/ResultSrc for forwarding and load-use detection.

## Interface
- ALUCTRL_W, 4, ALUControl width. Encoding is fixed in the low 4 bits; extra MSBs are tied 0.
- IMMSRC_W, 3, ImmSrc width; same zero-extension rule.

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- instrD  in  32  instruction in Decode
- validD  in  1  Decode holds a real instruction; 0 = bubble
- flushE  in  1  load a bubble into ID/EX at next edge
- ZeroE, LtE, LtuE  in  1 each  ALU flags: a==b, signed a<b, unsigned a<b
- ImmSrcD  out  IMMSRC_W  000 I, 001 S, 010 B, 011 J, 100 U
- illegalD  out  1  unsupported encoding in Decode
- ALUControlE  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB
- ALUSrcE  out  1  B operand = immediate
- ALUSrcAE  out  1  A operand = PC (auipc)
- PCSrcE  out  2  00 PC+4, 01 PC+imm (taken branch/jal), 10 rs1+imm (jalr)
- RegWriteE / RegWriteM / RegWriteW  out  1 each
- ResultSrcE / ResultSrcW  out  2 each  00 ALU, 01 memory, 10 PC+4
- MemWriteM  out  1
- funct3M  out  3  access size/sign for the memory stage

## Operation
- Decode is combinational from instrD. Supported opcodes: 33 (R), 13 (I-ALU), 03 (load), 23 (store), 63 (branch), 6F (jal), 67 (jalr), 37 (lui), 17 (auipc).
- R-type and I-ALU: funct3 and funct7[5] select the ALU op. funct7[5] applies only to R-type add/sub and to srl/sra.
- Branch funct3 mapping:
  - 000 beq: Zero
  - 001 bne: ~Zero
  - 100 blt: Lt
  - 101 bge: ~Lt
  - 110 bltu: Ltu
  - 111 bgeu: ~Ltu
  - 010 and 011 are illegal.
- lui: ALU op passB. auipc: ALUSrcA=1, ALU op add. Loads and stores: ALU op add.
- PCSrcE is combinational from the E-stage registers and the flags:
  - JumpE & ~jalrE gives 01.
  - jalrE gives 10.
  - BranchE & condition-true gives 01.
  - Otherwise 00.
- Bubble = all-zero control word: RegWrite, MemWrite, Branch and Jump all 0. The ID/EX register loads a bubble when flushE=1 or validD=0, or when illegalD=1 and the macro is defined.
- EX/MEM and MEM/WB always advance; they have no stall input.
- Writes to x0 are not suppressed here; the register file ignores them.

## Timing
- An instruction in D at cycle n presents E controls during n+1, M controls during n+2 and W controls during n+3.
- ImmSrcD and illegalD have zero latency from instrD.
- PCSrcE has zero latency from the E-stage registers and flags. It is valid the same cycle the branch is in E.
- Reset: every pipeline register clears to the bubble immediately and asynchronously. All E/M/W outputs are 0, so PCSrcE=00.
- Reset mid-operation drops MemWriteM and RegWriteW before the next edge.
- flushE together with validD=0: bubble; no conflict.
- flushE while a taken branch is in E: the branch still resolves that cycle. Only the next ID/EX content is killed.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - Unsupported opcodes, branch funct3 010/011, and a bad funct7 on R-type assert illegalD.
  - The instruction enters E as a bubble.
- Undefined:
  - illegalD is tied 0.
  - Unsupported encodings decode as a bubble with no side effects.

## Test plan
- beq x1,x2,8 (0x00208463) in D at n; ZeroE=1 at n+1 -> PCSrcE=01. Repeat with ZeroE=0 -> PCSrcE=00.
- blt (0x0020C463) with LtE=1, LtuE=0 -> 01. bltu (0x0020E463) with the same flags -> 00.
- jalr x1,0(x1) (0x000080E7) -> PCSrcE=10 at n+1; RegWriteW=1 and ResultSrcW=10 at n+3.
- lw x2,0(x1) (0x0000A103) -> ResultSrcE=01 at n+1, ResultSrcW=01 and RegWriteW=1 at n+3. sw (0x0020A023) -> MemWriteM=1, funct3M=010, RegWriteM=0 at n+2.
- beq in D with flushE=1 -> E is a bubble, PCSrcE=00 irrespective of ZeroE. Async rst pulse with sw in M -> MemWriteM=0 within the same cycle.
- instrD=0x00000000 with the macro defined -> illegalD=1, E is a bubble. Without the macro -> illegalD=0, E is a bubble.
